// File: rtl/tree_filler.sv
// Leaf-side refill feeder for the SORTER_STAGE_TREE merge tree: queues way requests, reads keys, returns tagged records.
// Define TREE_FILLER_DONE_EN to add the DONE output and the sent_cnt sentinel counter.
module tree_filler #(
    parameter int W_LOG    = 6,
    parameter int Q_SIZE   = 2,
    parameter int DATW     = 64,
    parameter int KEYW     = 32,
    parameter int DNUM_LOG = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [W_LOG-1:0]          I_REQUEST,
    input  logic                      I_REQUEST_VALID,
    output logic                      QUEUE_FULL,
    output logic [W_LOG+DNUM_LOG-1:0] MEM_RADDR,
    output logic                      MEM_RE,
    input  logic [KEYW-1:0]           MEM_RDATA,
    output logic [DATW-1:0]           DOT,
    output logic                      DOTEN,
    output logic [W_LOG-1:0]          DOT_IDX
`ifdef TREE_FILLER_DONE_EN
    ,
    output logic                      DONE
`endif
);

    localparam int WAYS  = 1 << W_LOG;
    localparam int DEPTH = 1 << Q_SIZE;
    localparam logic [DNUM_LOG:0] RCNT_MAX  = {1'b1, {DNUM_LOG{1'b0}}};
    localparam logic [Q_SIZE:0]   COUNT_MAX = {1'b1, {Q_SIZE{1'b0}}};

    logic [W_LOG-1:0]  queue_mem [DEPTH];
    logic [Q_SIZE-1:0] wr_ptr;
    logic [Q_SIZE-1:0] rd_ptr;
    logic [Q_SIZE:0]   q_count;
    logic [Q_SIZE:0]   q_count_next;
    logic              enq;
    logic              deq;
    logic [W_LOG-1:0]  head_way;
    logic              head_exhausted;
    logic [DNUM_LOG:0] rcnt [WAYS];
    logic              ret_valid;
    logic              ret_sent;
    logic [W_LOG-1:0]  ret_idx;

    always_comb begin
        enq            = I_REQUEST_VALID && !QUEUE_FULL;
        deq            = (q_count != '0);
        head_way       = queue_mem[rd_ptr];
        head_exhausted = (rcnt[head_way] == RCNT_MAX);
        MEM_RE         = deq && !head_exhausted;
        MEM_RADDR      = '0;
        if (MEM_RE) begin
            MEM_RADDR = {head_way, rcnt[head_way][DNUM_LOG-1:0]};
        end
        q_count_next = q_count;
        case ({enq, deq})
            2'b10:   q_count_next = q_count + 1'b1;
            2'b01:   q_count_next = q_count - 1'b1;
            default: q_count_next = q_count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            queue_mem[wr_ptr] <= I_REQUEST;
        end
    end

    // The counter bump lands on the same edge as the dequeue, so a following
    // request for the same way already sees the next offset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            QUEUE_FULL <= 1'b0;
            ret_valid  <= 1'b0;
            ret_sent   <= 1'b0;
            ret_idx    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                rcnt[w] <= '0;
            end
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr  <= rd_ptr + 1'b1;
                ret_idx <= head_way;
            end
            q_count    <= q_count_next;
            QUEUE_FULL <= (q_count_next == COUNT_MAX);
            ret_valid  <= deq;
            ret_sent   <= deq && head_exhausted;
            if (MEM_RE) begin
                rcnt[head_way] <= rcnt[head_way] + 1'b1;
            end
        end
    end

    always_comb begin
        DOTEN   = ret_valid;
        DOT_IDX = ret_idx;
        DOT     = '0;
        if (ret_valid) begin
            DOT = ret_sent ? {DATW{1'b1}} : {{(DATW-KEYW){1'b1}}, MEM_RDATA};
        end
    end

`ifdef TREE_FILLER_DONE_EN
    logic        all_exhausted;
    logic [15:0] sent_cnt;

    always_comb begin
        all_exhausted = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (rcnt[w] != RCNT_MAX) begin
                all_exhausted = 1'b0;
            end
        end
    end

    // A read returning this cycle is finished by the edge, so only an empty
    // queue (hence no issue) is needed beyond every way being exhausted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DONE     <= 1'b0;
            sent_cnt <= '0;
        end else begin
            if (all_exhausted && (q_count == '0)) begin
                DONE <= 1'b1;
            end
            if (ret_valid && ret_sent && (sent_cnt != 16'hFFFF)) begin
                sent_cnt <= sent_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/tree_filler.md
# tree_filler

Leaf-side feeder for the `SORTER_STAGE_TREE` virtual merge tree. Accepts way-index refill requests from the tree's leaf stage and queues them. For each request, reads the next unread key of that way from an external synchronous key memory and returns it to the tree tagged with its way index. Tracks a read count per way and substitutes the all-ones sentinel once a way is exhausted, so the tree drains cleanly.

## Interface
Parameters:
- `W_LOG`, 6: log2 of number of ways; request/index width.
- `Q_SIZE`, 2: log2 of request queue depth.
- `DATW`, 64: output record width.
- `KEYW`, 32: key width; memory data width.
- `DNUM_LOG`, 10: log2 of keys per way.

Ports (reset is synchronous and active-high; all state changes on rising `CLK`):
- `CLK`  in  1: clock.
- `RST`  in  1: synchronous active-high reset.
- `I_REQUEST`  in  `W_LOG`: way index requested by the tree.
- `I_REQUEST_VALID`  in  1: request strobe.
- `QUEUE_FULL`  out  1: request queue holds 2^`Q_SIZE` entries.
- `MEM_RADDR`  out  `W_LOG+DNUM_LOG`: key memory read address.
- `MEM_RE`  out  1: key memory read enable.
- `MEM_RDATA`  in  `KEYW`: read data, valid exactly 1 cycle after `MEM_RE`.
- `DOT`  out  `DATW`: record to tree.
- `DOTEN`  out  1: `DOT` valid.
- `DOT_IDX`  out  `W_LOG`: way index of `DOT`.

## Operation
- Request queue: FIFO, depth 2^`Q_SIZE`, count width `Q_SIZE+1`.
  - Enqueue when `I_REQUEST_VALID && !QUEUE_FULL`.
  - A request presented while full is dropped. Dropping a request is a tree protocol violation; the bench flags it.
  - Enqueue and dequeue in the same cycle: count unchanged.
- Issue stage: whenever the queue is non-empty, dequeue one entry per cycle. The tree never backpressures the filler.
- Per-way counter `rcnt[w]`, width `DNUM_LOG+1`, reset to 0.
- On dequeue of way w:
  - If `rcnt[w] != 2^DNUM_LOG`: assert `MEM_RE`, drive `MEM_RADDR = {w, rcnt[w][DNUM_LOG-1:0]}`, and increment `rcnt[w]` in the same cycle.
  - Else: `MEM_RE` = 0, mark the slot as sentinel, and leave the counter unchanged (saturated).
- Return stage, one cycle after issue: `DOTEN` = 1 and `DOT_IDX` = w.
  - `DOT = {{(DATW-KEYW){1'b1}}, MEM_RDATA}` for a real read.
  - `DOT = {DATW{1'b1}}` for a sentinel slot.
- Back-to-back requests for the same way read consecutive addresses. Because the counter update is visible to the next issue, no hazard exists.
- Requests are served strictly in arrival order.

## Timing
- Reset values:
  - Outputs: `QUEUE_FULL`, `MEM_RE`, and `DOTEN` are 0; `DOT`, `DOT_IDX`, and `MEM_RADDR` are 0.
  - State: all `rcnt` = 0, queue empty.
- Latency: a request enqueued at edge t is issued (`MEM_RE`) in cycle t+1. `DOTEN` is high in cycle t+2.
- Throughput: 1 record per cycle sustained.
- `QUEUE_FULL` is registered and reflects the count after the current edge.
- Reset mid-operation: the in-flight read is discarded and `DOTEN` = 0 from the cycle after `RST` is sampled high. Queued requests and counters are cleared.
- `MEM_RDATA` is sampled only in return-stage cycles of real reads; otherwise it is ignored.

## Configuration
- `TREE_FILLER_DONE_EN` defined:
  - Adds output port `DONE` (1 bit, reset 0).
  - `DONE` is set, and stays set until reset, once every way's `rcnt` equals 2^`DNUM_LOG`, the queue is empty, and no read is in flight.
  - Adds a 16-bit saturating `sent_cnt` counting sentinel records emitted, readable hierarchically.
- Undefined: no `DONE` port and no `sent_cnt`; behaviour is otherwise identical.

## Test plan
- Single request, way 3, `rcnt[3]` = 0 after reset, memory holds key `0x0000_1234` at address 3·1024:
  - `MEM_RE` at t+1 with `MEM_RADDR` = 3072.
  - At t+2: `DOTEN` = 1, `DOT` = `0xFFFFFFFF_00001234`, `DOT_IDX` = 3.
- Way 5 requested on 3 consecutive cycles: addresses 5120, 5121, 5122, one per cycle. `DOT` values are returned in order, with no bubbles.
- Exhaustion, `DNUM_LOG` = 1, way 0 requested 3 times:
  - Two real reads at addresses 0 and 1.
  - Third request: no `MEM_RE`; `DOT` = `0xFFFFFFFF_FFFFFFFF`, `DOT_IDX` = 0.
  - `rcnt[0]` stays at 2.
- Full/overflow: force `MEM_RE` path aside and hold the issue stage with `RST` pulsed only after filling? Instead, assert `I_REQUEST_VALID` for 6 consecutive cycles while the queue drains at 1 per cycle:
  - `QUEUE_FULL` never asserts.
  - Exactly 6 records are returned in request order.
- Reset mid-stream: assert `RST` for 1 cycle while a read is in flight.
  - `DOTEN` = 0 on the following cycle.
  - The next request to the same way reads offset 0.
- With `TREE_FILLER_DONE_EN`, `W_LOG` = 1, `DNUM_LOG` = 1, request ways 0,1,0,1:
  - `DONE` rises the cycle after the last record returns.
  - Two further requests yield 2 sentinels and `sent_cnt` = 2.
